d_flip_flop: RTL and testbench

- Parameterised, positive-edge D-type register stage: a WIDTH-bit input is captured into a STAGES-deep register chain.
- Adds clock enable, synchronous clear, complement output and per-bit change flags.
- Used as the basic storage or retiming element. With the default parameters it is a plain 1-bit DFF with q valid one clock after d is sampled.

---
 rtl/d_flip_flop.sv | 72 +++++++
 tb/tb_d_flip_flop.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// Parameterised D-type register chain with clock enable, synchronous clear,
// complement output and per-bit rise/fall flags derived from registered state.
`timescale 1ns/1ps
module d_flip_flop #(
  parameter int unsigned          WIDTH       = 1,
  parameter int unsigned          STAGES      = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("d_flip_flop: STAGES must be in 1..8");
  end

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];
  logic [WIDTH-1:0] prev_q_q;
  logic [WIDTH-1:0] prev_q_d;

  // clr outranks en; a cleared chain reloads the reset value in every stage
  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (clr) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_d[i] = RESET_VALUE;
      end
    end else if (en) begin
      stage_d[0] = d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // prev_q tracks q every edge, independent of en, so a hold yields no pulse
  always_comb begin
    prev_q_d = q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
      prev_q_q <= RESET_VALUE;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      prev_q_q <= prev_q_d;
    end
  end

  always_comb begin
    q    = stage_q[STAGES-1];
    q_n  = ~q;
    rise = q & ~prev_q_q;
    fall = ~q & prev_q_q;
  end

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: a default 1-bit instance and an 8-bit, 3-stage instance
// driven side by side, checked against a queue-based reference of accepted samples.
`timescale 1ns/1ps
module tb_d_flip_flop;

  localparam logic [7:0] Rv8 = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, en, clr;
  logic       d1;
  logic [7:0] d8;
  logic       q1, qn1, rise1, fall1;
  logic [7:0] q8, qn8, rise8, fall8;

  int n_checks = 0;
  int n_errors = 0;

  // reference: queue of the last STAGES accepted samples, newest at the front
  logic [7:0] m1[$];
  logic [7:0] m8[$];
  logic [7:0] p1, p8;

  d_flip_flop u_dff1 (
    .clk  (clk),
    .reset(reset),
    .d    (d1),
    .en   (en),
    .clr  (clr),
    .q    (q1),
    .q_n  (qn1),
    .rise (rise1),
    .fall (fall1)
  );

  d_flip_flop #(
    .WIDTH      (8),
    .STAGES     (3),
    .RESET_VALUE(Rv8)
  ) u_dff8 (
    .clk  (clk),
    .reset(reset),
    .d    (d8),
    .en   (en),
    .clr  (clr),
    .q    (q8),
    .q_n  (qn8),
    .rise (rise8),
    .fall (fall8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m1 = '{8'h00};
    m8 = '{Rv8, Rv8, Rv8};
    p1 = 8'h00;
    p8 = Rv8;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e1, e8;
    e1 = m1[$];
    e8 = m8[$];
    check_eq({tag, ".q1"},    {7'b0, q1},    e1);
    check_eq({tag, ".qn1"},   {7'b0, qn1},   ~e1 & 8'h01);
    check_eq({tag, ".rise1"}, {7'b0, rise1}, e1 & ~p1 & 8'h01);
    check_eq({tag, ".fall1"}, {7'b0, fall1}, ~e1 & p1 & 8'h01);
    check_eq({tag, ".q8"},    q8,    e8);
    check_eq({tag, ".qn8"},   qn8,   ~e8);
    check_eq({tag, ".rise8"}, rise8, e8 & ~p8);
    check_eq({tag, ".fall8"}, fall8, ~e8 & p8);
  endtask

  // one rising edge: update the reference from the inputs seen at the edge, then check
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      p1 = m1[$];
      p8 = m8[$];
      if (clr) begin
        m1 = '{8'h00};
        m8 = '{Rv8, Rv8, Rv8};
      end else if (en) begin
        m1.push_front({7'b0, d1});
        void'(m1.pop_back());
        m8.push_front(d8);
        void'(m8.pop_back());
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; clr = 1'b0; d1 = 1'b0; d8 = 8'h3C;
    model_reset();
    #2 check_all("por");
    check_eq("por.q8_const", q8, 8'hA5);
    #1 reset = 1'b0;

    // basic sequence: edge 5 ns
    tick("e1");
    check_eq("e1.q1_const", {7'b0, q1}, 8'h00);
    check_eq("e1.q8_hold_rv", q8, 8'hA5);
    d1 = 1'b1; d8 = 8'hFF;
    tick("e2");
    check_eq("e2.q1_const", {7'b0, q1}, 8'h01);
    check_eq("e2.rise1_const", {7'b0, rise1}, 8'h01);
    d1 = 1'b0; d8 = 8'h00;
    tick("e3");
    check_eq("e3.q1_const", {7'b0, q1}, 8'h00);
    check_eq("e3.q8_const", q8, 8'h3C);
    check_eq("e3.rise8_const", rise8, 8'h18);
    check_eq("e3.fall8_const", fall8, 8'h81);
    d1 = 1'b1;
    tick("e4");
    check_eq("e4.q1_const", {7'b0, q1}, 8'h01);
    check_eq("e4.q8_const", q8, 8'hFF);
    tick("e5");
    check_eq("e5.q8_const", q8, 8'h00);
    repeat (4) tick("steady");
    check_eq("steady.q1_const", {7'b0, q1}, 8'h01);

    // asynchronous reset between edges, released with d = 1
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("areset");
    check_eq("areset.q1_const", {7'b0, q1}, 8'h00);
    check_eq("areset.rise1_const", {7'b0, rise1}, 8'h00);
    check_eq("areset.fall1_const", {7'b0, fall1}, 8'h00);
    d1 = 1'b1;
    #1 reset = 1'b0;
    tick("post_rst");
    check_eq("post_rst.rise1_const", {7'b0, rise1}, 8'h01);
    tick("post_rst2");
    check_eq("post_rst2.rise1_const", {7'b0, rise1}, 8'h00);

    // enable hold with d toggling
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d1 = i[0];
      d8 = 8'(i * 37);
      tick("hold");
      check_eq("hold.q1_const", {7'b0, q1}, 8'h01);
      check_eq("hold.rise1_const", {7'b0, rise1}, 8'h00);
    end
    en = 1'b1; d1 = 1'b0;
    tick("hold_end");
    check_eq("hold_end.fall1_const", {7'b0, fall1}, 8'h01);

    // clr priority over en
    d1 = 1'b1;
    tick("pre_clr");
    clr = 1'b1;
    tick("clr");
    check_eq("clr.q1_const", {7'b0, q1}, 8'h00);
    check_eq("clr.fall1_const", {7'b0, fall1}, 8'h01);
    check_eq("clr.q8_const", q8, 8'hA5);
    clr = 1'b0;
    tick("post_clr");

    // clr and reset together: async path wins
    tick("pre_both");
    #2 clr = 1'b1; reset = 1'b1;
    #1 model_reset();
    check_all("both");
    check_eq("both.q1_const", {7'b0, q1}, 8'h00);
    #1 reset = 1'b0; clr = 1'b0;
    tick("post_both");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      d1  = 1'($urandom);
      d8  = 8'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) async_reset("rnd_rst");
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
